// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV32 pipeline: datapath and register-index
// widths, base opcode constants, the immediate-format selector and the
// decoded control bundle carried through the ID/EX pipeline register.
// No ports; imported by reg_file and id_stage.

package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Which immediate layout the instruction word uses. IMM_NONE covers OP,
  // bubbles and undecodable words, all of which carry a zero immediate.
  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Control bits that travel with an instruction into EX and beyond.
  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
    logic jalr;
    logic lui;
    logic auipc;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// reg_file
// Architectural integer register file: two combinational read ports and
// one write port. x0 always reads zero and ignores writes. A write and a
// read of the same register in one cycle return the new value, so the
// decode stage never sees a stale operand from writeback.
//
// Ports:
//   clk            clock, writes land on the rising edge
//   reset          synchronous active-high, clears every register
//   we/waddr/wdata write port
//   raddr1/raddr2  read indices
//   rdata1/rdata2  read data (bypassed)

module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0] raddr1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2
);

  import riscv_pkg::*;

  logic [XLEN-1:0] regs [NREG];

  // A write is only real when it targets a register other than x0.
  logic write_live;
  assign write_live = we && (waddr != '0);

  // Storage update. Reset wins over a simultaneous write; entry 0 is
  // cleared by reset and never written afterwards, so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (write_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: x0 is hardwired, then same-cycle bypass, then storage.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (write_live && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  // Read port 2: identical policy to port 1.
  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (write_live && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage
// Instruction-decode stage of the RV32 pipeline. Decodes the word held in
// the fetch pipeline register, builds the sign-extended immediate, reads
// operands from the register file (with writeback bypass) and registers
// the lot into the ID/EX pipeline register. JAL is resolved here: the
// redirect to fetch is combinational so the very next fetch edge can load
// the target and squash the following slot.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   if_data/if_pc/if_pc4       fetch pipeline register (if_data == 0 is a bubble)
//   wb_we/wb_rd/wb_data        register-file writeback port
//   control_j/pc_j             combinational JAL redirect to fetch
//   pipe_*                     ID/EX pipeline register outputs

module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             if_data,
  input  logic [XLEN-1:0]         if_pc,
  input  logic [XLEN-1:0]         if_pc4,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    control_j,
  output logic [XLEN-1:0]         pc_j,
  output logic [XLEN-1:0]         pipe_pc,
  output logic [XLEN-1:0]         pipe_pc4,
  output logic [XLEN-1:0]         pipe_rs1_data,
  output logic [XLEN-1:0]         pipe_rs2_data,
  output logic [XLEN-1:0]         pipe_imm,
  output logic [$clog2(NREG)-1:0] pipe_rd,
  output logic [2:0]              pipe_funct3,
  output logic                    pipe_funct7b5,
  output logic                    pipe_alu_src,
  output logic                    pipe_reg_write,
  output logic                    pipe_mem_read,
  output logic                    pipe_mem_write,
  output logic                    pipe_mem_to_reg,
  output logic                    pipe_branch,
  output logic                    pipe_jump,
  output logic                    pipe_jalr,
  output logic                    pipe_lui,
  output logic                    pipe_auipc,
  output logic                    pipe_illegal
);

  import riscv_pkg::*;

  localparam int AW = $clog2(NREG);

  logic [6:0]      opcode;
  logic [AW-1:0]   rs1_idx;
  logic [AW-1:0]   rs2_idx;
  logic [AW-1:0]   rd_idx;
  ctrl_t           ctrl;
  imm_type_e       imm_type;
  logic            legal;
  logic            illegal;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  ctrl_t           pipe_ctrl;

  assign opcode  = if_data[6:0];
  assign rd_idx  = AW'(if_data[11:7]);
  assign rs1_idx = AW'(if_data[19:15]);
  assign rs2_idx = AW'(if_data[24:20]);

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // Opcode decoder. Anything not in the table (including the all-zero
  // bubble) leaves every control bit clear, so an undecodable word flows
  // down the pipe exactly like a bubble; only the illegal flag differs.
  always_comb begin
    ctrl     = '0;
    imm_type = IMM_NONE;
    legal    = 1'b1;
    case (opcode)
      OPC_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.lui       = 1'b1;
        imm_type       = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.auipc     = 1'b1;
        imm_type       = IMM_U;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        imm_type       = IMM_J;
      end
      OPC_JALR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        imm_type       = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        imm_type    = IMM_B;
      end
      OPC_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        imm_type        = IMM_I;
      end
      OPC_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        imm_type       = IMM_S;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm_type       = IMM_I;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign illegal = !legal && (if_data != '0);

  // Immediate generator. All formats except U sign-extend from bit 31;
  // U is the upper 20 bits with the low 12 zero-filled.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{(XLEN-12){if_data[31]}}, if_data[31:20]};
      IMM_S: imm = {{(XLEN-12){if_data[31]}}, if_data[31:25], if_data[11:7]};
      IMM_B: imm = {{(XLEN-13){if_data[31]}}, if_data[31], if_data[7],
                    if_data[30:25], if_data[11:8], 1'b0};
      IMM_U: imm = XLEN'({if_data[31:12], 12'b0});
      IMM_J: imm = {{(XLEN-21){if_data[31]}}, if_data[31], if_data[19:12],
                    if_data[20], if_data[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // JAL redirect. Held off during reset so fetch is not steered by a word
  // that is about to be discarded; the target is zero whenever no redirect
  // is requested so fetch never sees a stray address.
  always_comb begin
    control_j = 1'b0;
    pc_j      = '0;
    if (!reset && ctrl.jump) begin
      control_j = 1'b1;
      pc_j      = if_pc + imm;
    end
  end

  // ID/EX pipeline register. PCs track their inputs even for bubbles so
  // downstream diagnostics still see where the slot came from; rd is
  // zeroed for non-decodable slots so nothing downstream can match on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_pc       <= '0;
      pipe_pc4      <= '0;
      pipe_rs1_data <= '0;
      pipe_rs2_data <= '0;
      pipe_imm      <= '0;
      pipe_rd       <= '0;
      pipe_funct3   <= '0;
      pipe_funct7b5 <= 1'b0;
      pipe_ctrl     <= '0;
      pipe_illegal  <= 1'b0;
    end else begin
      pipe_pc       <= if_pc;
      pipe_pc4      <= if_pc4;
      pipe_rs1_data <= rs1_data;
      pipe_rs2_data <= rs2_data;
      pipe_imm      <= imm;
      pipe_rd       <= legal ? rd_idx : '0;
      pipe_funct3   <= if_data[14:12];
      pipe_funct7b5 <= if_data[30];
      pipe_ctrl     <= ctrl;
      pipe_illegal  <= illegal;
    end
  end

  assign pipe_alu_src    = pipe_ctrl.alu_src;
  assign pipe_reg_write  = pipe_ctrl.reg_write;
  assign pipe_mem_read   = pipe_ctrl.mem_read;
  assign pipe_mem_write  = pipe_ctrl.mem_write;
  assign pipe_mem_to_reg = pipe_ctrl.mem_to_reg;
  assign pipe_branch     = pipe_ctrl.branch;
  assign pipe_jump       = pipe_ctrl.jump;
  assign pipe_jalr       = pipe_ctrl.jalr;
  assign pipe_lui        = pipe_ctrl.lui;
  assign pipe_auipc      = pipe_ctrl.auipc;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage
// Self-checking bench for id_stage: directed scenarios plus a randomized
// run compared against an instruction-level reference model (decode table,
// immediate formulas and a shadow register array).

module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_data, if_pc, if_pc4;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        control_j;
  logic [31:0] pc_j, pipe_pc, pipe_pc4, pipe_rs1_data, pipe_rs2_data, pipe_imm;
  logic [4:0]  pipe_rd;
  logic [2:0]  pipe_funct3;
  logic        pipe_funct7b5, pipe_alu_src, pipe_reg_write, pipe_mem_read;
  logic        pipe_mem_write, pipe_mem_to_reg, pipe_branch, pipe_jump;
  logic        pipe_jalr, pipe_lui, pipe_auipc, pipe_illegal;

  int compared   = 0;
  int mismatched = 0;

  // Control bit positions in the observed/expected 10-bit vector.
  localparam int C_ALU = 9, C_RW = 8, C_MR = 7, C_MW = 6, C_MTR = 5;
  localparam int C_BR = 4, C_J = 3, C_JR = 2, C_LUI = 1, C_AUI = 0;

  wire [9:0] obs_ctl = {pipe_alu_src, pipe_reg_write, pipe_mem_read, pipe_mem_write,
                        pipe_mem_to_reg, pipe_branch, pipe_jump, pipe_jalr,
                        pipe_lui, pipe_auipc};

  logic [31:0] model_regs [32];

  typedef struct {
    logic        legal;
    logic        illegal;
    logic        is_jal;
    logic [9:0]  ctl;
    logic [31:0] imm;
    logic [4:0]  rd;
  } exp_t;

  id_stage #(.XLEN(32), .NREG(32)) dut (
    .clk (clk), .reset (reset),
    .if_data (if_data), .if_pc (if_pc), .if_pc4 (if_pc4),
    .wb_we (wb_we), .wb_rd (wb_rd), .wb_data (wb_data),
    .control_j (control_j), .pc_j (pc_j),
    .pipe_pc (pipe_pc), .pipe_pc4 (pipe_pc4),
    .pipe_rs1_data (pipe_rs1_data), .pipe_rs2_data (pipe_rs2_data),
    .pipe_imm (pipe_imm), .pipe_rd (pipe_rd),
    .pipe_funct3 (pipe_funct3), .pipe_funct7b5 (pipe_funct7b5),
    .pipe_alu_src (pipe_alu_src), .pipe_reg_write (pipe_reg_write),
    .pipe_mem_read (pipe_mem_read), .pipe_mem_write (pipe_mem_write),
    .pipe_mem_to_reg (pipe_mem_to_reg), .pipe_branch (pipe_branch),
    .pipe_jump (pipe_jump), .pipe_jalr (pipe_jalr),
    .pipe_lui (pipe_lui), .pipe_auipc (pipe_auipc),
    .pipe_illegal (pipe_illegal)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference decode: opcode table and immediate layouts, sign extension
  // done by signed casts of each assembled immediate field.
  function automatic exp_t predict(input logic [31:0] ins);
    exp_t e;
    e.legal = 1'b1; e.illegal = 1'b0; e.is_jal = 1'b0;
    e.ctl = '0; e.imm = '0; e.rd = ins[11:7];
    case (ins[6:0])
      7'b0110111: begin e.ctl[C_ALU] = 1; e.ctl[C_RW] = 1; e.ctl[C_LUI] = 1;
                        e.imm = {ins[31:12], 12'h000}; end
      7'b0010111: begin e.ctl[C_ALU] = 1; e.ctl[C_RW] = 1; e.ctl[C_AUI] = 1;
                        e.imm = {ins[31:12], 12'h000}; end
      7'b1101111: begin e.ctl[C_RW] = 1; e.ctl[C_J] = 1; e.is_jal = 1'b1;
                        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'b1100111: begin e.ctl[C_ALU] = 1; e.ctl[C_RW] = 1; e.ctl[C_JR] = 1;
                        e.imm = 32'($signed(ins[31:20])); end
      7'b1100011: begin e.ctl[C_BR] = 1;
                        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'b0000011: begin e.ctl[C_ALU] = 1; e.ctl[C_RW] = 1; e.ctl[C_MR] = 1; e.ctl[C_MTR] = 1;
                        e.imm = 32'($signed(ins[31:20])); end
      7'b0100011: begin e.ctl[C_ALU] = 1; e.ctl[C_MW] = 1;
                        e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'b0010011: begin e.ctl[C_ALU] = 1; e.ctl[C_RW] = 1;
                        e.imm = 32'($signed(ins[31:20])); end
      7'b0110011: begin e.ctl[C_RW] = 1; end
      default:    begin e.legal = 1'b0; e.illegal = (ins != 32'd0); e.rd = 5'd0; end
    endcase
    return e;
  endfunction

  // Drive one cycle's worth of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                               input logic we, input logic [4:0] rd, input logic [31:0] data);
    reset = rst; if_data = ins; if_pc = pc; if_pc4 = pc + 32'd4;
    wb_we = we; wb_rd = rd; wb_data = data;
    #1;
  endtask

  // Commit this cycle's effect to the shadow registers, then advance one
  // edge. Operands expected afterwards are the post-write register values.
  task automatic clockEdge();
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (wb_we && wb_rd != 5'd0) begin
      model_regs[wb_rd] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 32'h028000EF, 32'h100, 1'b1, 5'd3, 32'hCAFEF00D);
    compared++; if (control_j !== 1'b0) begin mismatched++;
      $display("[TB] FAIL reset_control_j: got %b want 0", control_j); end
    compared++; if (pc_j !== 32'd0) begin mismatched++;
      $display("[TB] FAIL reset_pc_j: got %h want 0", pc_j); end
    clockEdge();
    clockEdge();
    compared++; if ({pipe_pc, pipe_pc4, pipe_rs1_data, pipe_rs2_data, pipe_imm} !== 160'd0) begin
      mismatched++; $display("[TB] FAIL reset_pipe_data: got %h %h %h %h %h want all 0",
                             pipe_pc, pipe_pc4, pipe_rs1_data, pipe_rs2_data, pipe_imm); end
    compared++; if ({obs_ctl, pipe_rd, pipe_funct3, pipe_funct7b5, pipe_illegal} !== 20'd0) begin
      mismatched++; $display("[TB] FAIL reset_pipe_ctl: got ctl=%b rd=%0d f3=%0d f7b5=%b ill=%b want all 0",
                             obs_ctl, pipe_rd, pipe_funct3, pipe_funct7b5, pipe_illegal); end
    // add x7, x1, x31 straight out of reset
    applyStimulus(1'b0, 32'h01F083B3, 32'h0, 1'b0, 5'd0, 32'd0);
    clockEdge();
    compared++; if (pipe_rs1_data !== 32'd0 || pipe_rs2_data !== 32'd0) begin mismatched++;
      $display("[TB] FAIL reset_add_operands: got %h/%h want 0/0", pipe_rs1_data, pipe_rs2_data); end
    compared++; if (pipe_rd !== 5'd7 || obs_ctl !== 10'b0100000000) begin mismatched++;
      $display("[TB] FAIL reset_add_decode: got rd=%0d ctl=%b want rd=7 ctl=0100000000", pipe_rd, obs_ctl); end
  endtask

  task automatic test_bypass();
    // addi x6, x5, -1 while x5 is being written the same cycle
    applyStimulus(1'b0, 32'hFFF28313, 32'h4, 1'b1, 5'd5, 32'h12345678);
    clockEdge();
    compared++; if (pipe_rs1_data !== 32'h12345678) begin mismatched++;
      $display("[TB] FAIL bypass_rs1: got %h want 12345678", pipe_rs1_data); end
    compared++; if (pipe_imm !== 32'hFFFFFFFF) begin mismatched++;
      $display("[TB] FAIL bypass_imm: got %h want ffffffff", pipe_imm); end
    compared++; if (pipe_rd !== 5'd6 || pipe_reg_write !== 1'b1 || pipe_alu_src !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bypass_ctl: got rd=%0d rw=%b alu=%b want 6/1/1",
                             pipe_rd, pipe_reg_write, pipe_alu_src); end
  endtask

  task automatic test_jal();
    applyStimulus(1'b0, 32'h028000EF, 32'h48, 1'b0, 5'd0, 32'd0);
    compared++; if (control_j !== 1'b1 || pc_j !== 32'h70) begin mismatched++;
      $display("[TB] FAIL jal_redirect: got cj=%b pc_j=%h want 1/00000070", control_j, pc_j); end
    clockEdge();
    compared++; if (pipe_jump !== 1'b1 || pipe_rd !== 5'd1 || pipe_reg_write !== 1'b1) begin mismatched++;
      $display("[TB] FAIL jal_pipe_ctl: got jump=%b rd=%0d rw=%b want 1/1/1", pipe_jump, pipe_rd, pipe_reg_write); end
    compared++; if (pipe_pc4 !== 32'h4C || pipe_imm !== 32'h28) begin mismatched++;
      $display("[TB] FAIL jal_pipe_data: got pc4=%h imm=%h want 0000004c/00000028", pipe_pc4, pipe_imm); end
  endtask

  task automatic test_store();
    applyStimulus(1'b0, 32'hFE21AE23, 32'h50, 1'b0, 5'd0, 32'd0);
    clockEdge();
    compared++; if (pipe_imm !== 32'hFFFFFFFC) begin mismatched++;
      $display("[TB] FAIL store_imm: got %h want fffffffc", pipe_imm); end
    compared++; if (pipe_mem_write !== 1'b1 || pipe_reg_write !== 1'b0 || pipe_funct3 !== 3'd2) begin
      mismatched++; $display("[TB] FAIL store_ctl: got mw=%b rw=%b f3=%0d want 1/0/2",
                             pipe_mem_write, pipe_reg_write, pipe_funct3); end
  endtask

  task automatic test_x0_and_bubble();
    applyStimulus(1'b0, 32'h0, 32'h200, 1'b1, 5'd0, 32'hFFFFFFFF);
    compared++; if (control_j !== 1'b0) begin mismatched++;
      $display("[TB] FAIL bubble_control_j: got %b want 0", control_j); end
    clockEdge();
    compared++; if (obs_ctl !== 10'd0 || pipe_rd !== 5'd0 || pipe_imm !== 32'd0 || pipe_illegal !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bubble_pipe: got ctl=%b rd=%0d imm=%h ill=%b want all 0",
                             obs_ctl, pipe_rd, pipe_imm, pipe_illegal); end
    compared++; if (pipe_pc !== 32'h200 || pipe_pc4 !== 32'h204) begin mismatched++;
      $display("[TB] FAIL bubble_pcs: got %h/%h want 00000200/00000204", pipe_pc, pipe_pc4); end
    // add x7, x0, x0 with another x0 write landing the same cycle
    applyStimulus(1'b0, 32'h000003B3, 32'h204, 1'b1, 5'd0, 32'hFFFFFFFF);
    clockEdge();
    compared++; if (pipe_rs1_data !== 32'd0 || pipe_rs2_data !== 32'd0) begin mismatched++;
      $display("[TB] FAIL x0_operands: got %h/%h want 0/0", pipe_rs1_data, pipe_rs2_data); end
  endtask

  task automatic test_illegal();
    applyStimulus(1'b0, 32'h0000007F, 32'h300, 1'b0, 5'd0, 32'd0);
    clockEdge();
    compared++; if (pipe_illegal !== 1'b1 || obs_ctl !== 10'd0 || pipe_rd !== 5'd0) begin mismatched++;
      $display("[TB] FAIL illegal_flag: got ill=%b ctl=%b rd=%0d want 1/0/0", pipe_illegal, obs_ctl, pipe_rd); end
    applyStimulus(1'b0, 32'hFFF28313, 32'h304, 1'b0, 5'd0, 32'd0);
    clockEdge();
    compared++; if (pipe_illegal !== 1'b0) begin mismatched++;
      $display("[TB] FAIL illegal_one_cycle: got %b want 0", pipe_illegal); end
  endtask

  task automatic test_reset_mid_jal();
    applyStimulus(1'b0, 32'h0, 32'h400, 1'b1, 5'd9, 32'hDEADBEEF);
    clockEdge();
    applyStimulus(1'b1, 32'h028000EF, 32'h48, 1'b1, 5'd10, 32'h00000055);
    compared++; if (control_j !== 1'b0 || pc_j !== 32'd0) begin mismatched++;
      $display("[TB] FAIL reset_jal_redirect: got cj=%b pc_j=%h want 0/0", control_j, pc_j); end
    clockEdge();
    compared++; if (pipe_jump !== 1'b0 || pipe_rd !== 5'd0 || pipe_pc !== 32'd0) begin mismatched++;
      $display("[TB] FAIL reset_jal_pipe: got jump=%b rd=%0d pc=%h want 0/0/0", pipe_jump, pipe_rd, pipe_pc); end
    // add x11, x9, x10: both were cleared (x10's write was overridden)
    applyStimulus(1'b0, 32'h00A485B3, 32'h0, 1'b0, 5'd0, 32'd0);
    clockEdge();
    compared++; if (pipe_rs1_data !== 32'd0 || pipe_rs2_data !== 32'd0) begin mismatched++;
      $display("[TB] FAIL reset_clears_regs: got %h/%h want 0/0", pipe_rs1_data, pipe_rs2_data); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins, pc;
      logic        rst, exp_cj;
      logic [31:0] exp_pcj;
      exp_t        e;
      int          kind;
      kind = int'($urandom_range(0, 11));
      ins  = $urandom;
      if (kind == 0) begin
        ins = 32'd0;
      end else if (kind == 1) begin
        e = predict(ins);
        while (e.legal || ins == 32'd0) begin
          ins = $urandom;
          e = predict(ins);
        end
      end else begin
        ins[6:0] = ops[kind - 2 - ((kind - 2) / 9) * 9];
      end
      pc  = $urandom & 32'hFFFFFFFC;
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus(rst, ins, pc, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      e       = predict(ins);
      exp_cj  = !rst && e.is_jal;
      exp_pcj = exp_cj ? pc + e.imm : 32'd0;
      compared++; if (control_j !== exp_cj || pc_j !== exp_pcj) begin mismatched++;
        $display("[TB] FAIL rand_redirect[%0d] ins=%h: got %b/%h want %b/%h", n, ins, control_j, pc_j, exp_cj, exp_pcj); end
      clockEdge();
      if (rst) begin
        compared++; if ({obs_ctl, pipe_rd, pipe_illegal} !== 16'd0 || pipe_pc !== 32'd0 || pipe_imm !== 32'd0) begin
          mismatched++; $display("[TB] FAIL rand_reset[%0d]: got ctl=%b rd=%0d ill=%b pc=%h imm=%h want all 0",
                                 n, obs_ctl, pipe_rd, pipe_illegal, pipe_pc, pipe_imm); end
      end else begin
        compared++; if (obs_ctl !== e.ctl || pipe_rd !== e.rd || pipe_illegal !== e.illegal) begin mismatched++;
          $display("[TB] FAIL rand_decode[%0d] ins=%h: got ctl=%b rd=%0d ill=%b want ctl=%b rd=%0d ill=%b",
                   n, ins, obs_ctl, pipe_rd, pipe_illegal, e.ctl, e.rd, e.illegal); end
        compared++; if (pipe_imm !== e.imm || pipe_pc !== pc || pipe_pc4 !== pc + 32'd4) begin mismatched++;
          $display("[TB] FAIL rand_imm_pc[%0d] ins=%h: got imm=%h pc=%h pc4=%h want %h/%h/%h",
                   n, ins, pipe_imm, pipe_pc, pipe_pc4, e.imm, pc, pc + 32'd4); end
        if (e.legal || ins == 32'd0) begin
          compared++; if (pipe_rs1_data !== model_regs[ins[19:15]] || pipe_rs2_data !== model_regs[ins[24:20]]) begin
            mismatched++; $display("[TB] FAIL rand_operands[%0d] ins=%h: got %h/%h want %h/%h", n, ins,
                                   pipe_rs1_data, pipe_rs2_data, model_regs[ins[19:15]], model_regs[ins[24:20]]); end
          compared++; if (pipe_funct3 !== ins[14:12] || pipe_funct7b5 !== ins[30]) begin mismatched++;
            $display("[TB] FAIL rand_funct[%0d] ins=%h: got %0d/%b want %0d/%b", n, ins,
                     pipe_funct3, pipe_funct7b5, ins[14:12], ins[30]); end
        end
      end
    end
  endtask

  // Scenario sequence; every scenario leaves the shadow model in step
  // with the DUT so later scenarios can rely on it.
  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    reset = 1'b1; if_data = '0; if_pc = '0; if_pc4 = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_bypass();
    test_jal();
    test_store();
    test_x0_and_bubble();
    test_illegal();
    test_reset_mid_jal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
